// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   imem_state_e : load/run control states
//   BYTE_W       : width of one program byte on the load stream
//   NOP          : all-zero instruction returned on a faulting fetch
package imem_pkg;

  localparam int BYTE_W = 8;

  // Wide enough for any sensible instruction width; users slice the low bits.
  localparam logic [127:0] NOP = 128'h0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one synchronous read port
// with a registered output.
//   we/waddr/wdata : write port, written on the rising edge
//   re/raddr       : read port; rdata updates only when re is high
//   rd_nop         : when high together with re, rdata loads the NOP word
//                    instead of the array contents
//   rdata          : registered read data (cleared by reset; the array is not)
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rd_nop,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Storage array write port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read data: hold unless a read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rd_nop ? NOP[DATA_W-1:0] : mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Registered read output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory loaded over a byte stream, then fetched by byte address.
//   ld_start/ld_valid/ld_byte/ld_last : program-load stream (big-endian bytes)
//   ld_ready/ld_done/word_count       : load handshake, end pulse, words written
//   fetch_req/fetch_addr/fetch_ready  : fetch request handshake (RUN only)
//   instr/instr_valid/fetch_err       : fetch response, one cycle after accept
module imem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_start,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    ld_done,
  output logic [$clog2(DEPTH):0]  word_count,
  input  logic                    fetch_req,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic                    fetch_ready,
  output logic [DATA_W-1:0]       instr,
  output logic                    instr_valid,
  output logic                    fetch_err
);

  localparam int BPW   = DATA_W / BYTE_W;
  localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * BPW);

  imem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_done_q, ld_done_d;
  logic              fetch_ready_q, fetch_ready_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic              ld_acc_s;
  logic              word_done_s;
  logic [DATA_W-1:0] asm_shift_s;
  logic [BC_W-1:0]   pad_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              fetch_acc_s;
  logic              fetch_ok_s;
  logic [IDX_W-1:0]  ram_raddr_s;

  // Load-side datapath: shift in the byte, and left-justify a short final
  // word so its missing low bytes come out as zeros.
  always_comb begin
    ld_acc_s    = ld_valid && ld_ready_q;
    asm_shift_s = (asm_q << BYTE_W) | DATA_W'(ld_byte);
    word_done_s = ld_last || (byte_cnt_q == BC_W'(BPW - 1));
    pad_s       = BC_W'(BPW - 1) - byte_cnt_q;
    ram_wdata_s = asm_shift_s << (32'(pad_s) * BYTE_W);
  end

  // Control FSM next state, counters and load outputs.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    ld_done_d    = 1'b0;
    ram_we_s     = 1'b0;
    case (state_q)
      EMPTY, RUN: begin
        if (ld_start) begin
          state_d      = LOAD;
          word_count_d = '0;
          byte_cnt_d   = '0;
          asm_d        = '0;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        // ld_start is ignored here; ld_ready_q already implies LOAD.
        if (ld_acc_s) begin
          if (word_done_s) begin
            ram_we_s     = 1'b1;
            word_count_d = word_count_q + CNT_W'(1);
            byte_cnt_d   = '0;
            asm_d        = '0;
            if (ld_last || (word_count_d == CNT_W'(DEPTH))) begin
              state_d   = RUN;
              ld_done_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            asm_d      = asm_shift_s;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Ready flags are registered from the next state so they line up with it.
    ld_ready_d    = (state_d == LOAD) && (word_count_d < CNT_W'(DEPTH));
    fetch_ready_d = (state_d == RUN);
  end

  // Fetch decode: alignment, range and word index.
  always_comb begin
    fetch_acc_s   = fetch_req && fetch_ready_q;
    fetch_ok_s    = ((fetch_addr & ADDR_W'(BPW - 1)) == '0) &&
                    ({1'b0, fetch_addr} < MEM_BYTES);
    ram_raddr_s   = IDX_W'(fetch_addr >> OFF_W);
    instr_valid_d = fetch_acc_s;
    fetch_err_d   = fetch_acc_s && !fetch_ok_s;
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      word_count_q  <= '0;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      fetch_ready_q <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      ld_ready_q    <= ld_ready_d;
      ld_done_q     <= ld_done_d;
      fetch_ready_q <= fetch_ready_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Faulting fetches load NOP into the read register, so instr needs no mux
  // and holds its value between fetches.
  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (ram_we_s),
    .waddr  (word_count_q[IDX_W-1:0]),
    .wdata  (ram_wdata_s),
    .re     (fetch_acc_s),
    .rd_nop (!fetch_ok_s),
    .raddr  (ram_raddr_s),
    .rdata  (instr)
  );

  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign word_count  = word_count_q;
  assign fetch_ready = fetch_ready_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  // DEPTH=64 instance
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_ready, ld_done;
  logic [6:0]  word_count;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_ready, instr_valid, fetch_err;
  logic [31:0] instr;
  // DEPTH=4 instance
  logic        ld_start4 = 1'b0, ld_valid4 = 1'b0, ld_last4 = 1'b0;
  logic [7:0]  ld_byte4 = 8'h00;
  logic        ld_ready4, ld_done4;
  logic [2:0]  word_count4;
  logic        fetch_req4 = 1'b0;
  logic [31:0] fetch_addr4 = 32'h0;
  logic        fetch_ready4, instr_valid4, fetch_err4;
  logic [31:0] instr4;

  int assertions = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_cnt4 = 0;
  logic [32:0] exp_q[$];          // {instr, fetch_err}
  logic [7:0]  pkt[$];
  logic [31:0] model_mem [64];

  imem_loadable #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
    .word_count(word_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instr(instr), .instr_valid(instr_valid),
    .fetch_err(fetch_err));

  imem_loadable #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start4), .ld_valid(ld_valid4),
    .ld_byte(ld_byte4), .ld_last(ld_last4), .ld_ready(ld_ready4), .ld_done(ld_done4),
    .word_count(word_count4), .fetch_req(fetch_req4), .fetch_addr(fetch_addr4),
    .fetch_ready(fetch_ready4), .instr(instr4), .instr_valid(instr_valid4),
    .fetch_err(fetch_err4));

  always #5 clk = ~clk;

  // Scoreboard: every instr_valid on the main DUT must match a queued expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && instr_valid) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_instr_valid: got instr=%h err=%b, required no response", instr, fetch_err);
      end else begin
        e = exp_q.pop_front();
        if ({instr, fetch_err} !== e) begin
          failures++;
          $display("FAIL fetch_response: got instr=%h err=%b, required instr=%h err=%b",
                   instr, fetch_err, e[32:1], e[0]);
        end
      end
    end
    if (ld_done) done_cnt++;
    if (ld_done4) done_cnt4++;
  end

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] exp_instr, input logic exp_err);
    fetch_req = 1'b1; fetch_addr = addr;
    assertions++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL fetch_ready_run: got %b, required 1 (addr %h)", fetch_ready, addr);
    end else begin
      exp_q.push_back({exp_instr, exp_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch_idle();
    fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_pkt(input string name, input bit do_start);
    int n, bc, wc, waits, d0;
    logic [31:0] a;
    n = pkt.size(); bc = 0; wc = 0; a = 32'h0; d0 = done_cnt;
    if (do_start) begin
      ld_start = 1'b1; @(posedge clk); #1; ld_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_byte = pkt[i]; ld_last = (i == n - 1);
      waits = 0;
      while (ld_ready !== 1'b1 && waits < 20) begin @(posedge clk); #1; waits++; end
      if (ld_ready !== 1'b1) begin
        assertions++; failures++;
        $display("FAIL %s_ld_ready: got %b, required 1 within 20 cycles", name, ld_ready);
        break;
      end
      @(posedge clk); #1;
      a = (a << 8) | 32'(pkt[i]); bc++;
      if (bc == 4 || i == n - 1) begin
        model_mem[wc] = a << (8 * (4 - bc)); wc++; bc = 0; a = 32'h0;
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    assertions++;
    if (ld_done !== 1'b1) begin failures++; $display("FAIL %s_ld_done: got %b, required 1", name, ld_done); end
    assertions++;
    if (word_count !== 7'(wc)) begin failures++; $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, wc); end
    assertions++;
    if (dut.state_q !== RUN) begin failures++; $display("FAIL %s_state: got %0d, required RUN", name, dut.state_q); end
    @(posedge clk); #1;
    assertions++;
    if (ld_done !== 1'b0) begin failures++; $display("FAIL %s_ld_done_pulse: got %b, required 0", name, ld_done); end
    assertions++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - d0); end
  endtask

  task automatic check_drained(input string name);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got %0d outstanding responses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    assertions++;
    if ({ld_ready, ld_done, fetch_ready, instr_valid, fetch_err} !== 5'b0 || word_count !== 7'd0 ||
        instr !== 32'h0 || dut.state_q !== EMPTY) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b done=%b wc=%0d frdy=%b instr=%h v=%b err=%b st=%0d, required all zero, EMPTY",
               ld_ready, ld_done, word_count, fetch_ready, instr, instr_valid, fetch_err, dut.state_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Fetch in EMPTY must be ignored.
    fetch_req = 1'b1; fetch_addr = 32'h0;
    assertions++;
    if (fetch_ready !== 1'b0) begin failures++; $display("FAIL empty_fetch_ready: got %b, required 0", fetch_ready); end
    fetch_idle();
  endtask

  task automatic test_load_basic();
    pkt = '{8'h20, 8'h10, 8'h00, 8'h00, 8'h20, 8'h04, 8'h00, 8'hA1};
    load_pkt("basic", 1'b1);
    fetch_one(32'h4, 32'h200400A1, 1'b0);
    fetch_one(32'h0, 32'h20100000, 1'b0);
    fetch_idle();
    check_drained("basic");
  endtask

  task automatic test_partial_retain();
    pkt = '{};
    for (int i = 0; i < 12; i++) pkt.push_back(8'($urandom_range(1, 255)));
    load_pkt("three_words", 1'b1);
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    load_pkt("partial", 1'b1);
    fetch_one(32'h4, 32'hEEFF0000, 1'b0);
    fetch_one(32'h0, 32'hAABBCCDD, 1'b0);
    fetch_one(32'h8, model_mem[2], 1'b0);   // untouched by the second session
    fetch_idle();
    check_drained("partial");
  endtask

  task automatic test_back_to_back_errors();
    fetch_one(32'h6, 32'h0, 1'b1);
    fetch_one(32'h100, 32'h0, 1'b1);
    fetch_one(32'hFF, 32'h0, 1'b1);
    fetch_one(32'h8, model_mem[2], 1'b0);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    check_drained("b2b");
  endtask

  task automatic test_hold();
    fetch_one(32'h0, 32'hAABBCCDD, 1'b0);
    fetch_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    assertions++;
    if (instr_valid !== 1'b0 || instr !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL instr_hold: got instr=%h v=%b, required AABBCCDD v=0", instr, instr_valid);
    end
    check_drained("hold");
  endtask

  task automatic test_fetch_with_ldstart();
    fetch_req = 1'b1; fetch_addr = 32'h4;
    exp_q.push_back({32'hEEFF0000, 1'b0});
    ld_start = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0; ld_start = 1'b0;
    assertions++;
    if (instr_valid !== 1'b1 || dut.state_q !== LOAD || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ldstart: got v=%b st=%0d frdy=%b, required v=1 LOAD frdy=0", instr_valid, dut.state_q, fetch_ready);
    end
    pkt = '{8'h13, 8'h57, 8'h9B, 8'hDF};
    load_pkt("reload", 1'b0);
    fetch_one(32'h0, 32'h13579BDF, 1'b0);
    fetch_one(32'h4, 32'hEEFF0000, 1'b0);
    fetch_idle();
    check_drained("reload");
  endtask

  task automatic test_auto_end();
    int acc, d0;
    bit took;
    ld_start4 = 1'b1; @(posedge clk); #1; ld_start4 = 1'b0;
    acc = 0; d0 = done_cnt4;
    for (int i = 0; i < 20; i++) begin
      ld_valid4 = 1'b1; ld_byte4 = 8'(i + 1); ld_last4 = 1'b0;
      took = (ld_ready4 === 1'b1);
      @(posedge clk); #1;
      if (took) begin
        acc++;
        if (acc == 16) begin
          assertions++;
          if (ld_ready4 !== 1'b0 || ld_done4 !== 1'b1 || dut4.state_q !== RUN || word_count4 !== 3'd4) begin
            failures++;
            $display("FAIL auto_end: got rdy=%b done=%b st=%0d wc=%0d, required rdy=0 done=1 RUN wc=4",
                     ld_ready4, ld_done4, dut4.state_q, word_count4);
          end
        end
      end
    end
    ld_valid4 = 1'b0;
    assertions++;
    if (acc != 16) begin failures++; $display("FAIL auto_end_accepted: got %0d bytes, required 16", acc); end
    assertions++;
    if (done_cnt4 - d0 != 1) begin failures++; $display("FAIL auto_end_done_count: got %0d, required 1", done_cnt4 - d0); end
    fetch_req4 = 1'b1; fetch_addr4 = 32'hC;
    @(posedge clk); #1;
    fetch_req4 = 1'b0;
    assertions++;
    if (instr_valid4 !== 1'b1 || instr4 !== 32'h0D0E0F10 || fetch_err4 !== 1'b0) begin
      failures++;
      $display("FAIL auto_end_fetch: got v=%b instr=%h err=%b, required v=1 instr=0D0E0F10 err=0",
               instr_valid4, instr4, fetch_err4);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1; @(posedge clk); #1; ld_start = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'hDE; @(posedge clk); #1;
    ld_byte = 8'hAD; @(posedge clk); #1;
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({ld_ready, ld_done, fetch_ready, instr_valid, fetch_err} !== 5'b0 || word_count !== 7'd0 ||
        instr !== 32'h0 || dut.state_q !== EMPTY) begin
      failures++;
      $display("FAIL midload_reset: got rdy=%b done=%b wc=%0d frdy=%b instr=%h v=%b err=%b st=%0d, required all zero, EMPTY",
               ld_ready, ld_done, word_count, fetch_ready, instr, instr_valid, fetch_err, dut.state_q);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    assertions++;
    if (fetch_ready !== 1'b0) begin failures++; $display("FAIL post_reset_fetch_ready: got %b, required 0", fetch_ready); end
    fetch_idle();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_pkt("after_reset", 1'b1);
    fetch_one(32'h0, 32'h11223344, 1'b0);
    fetch_one(32'h4, 32'h55000000, 1'b0);
    fetch_idle();
    check_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_partial_retain();
    test_back_to_back_errors();
    test_hold();
    test_fetch_with_ldstart();
    test_auto_end();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
